dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter for the single data-memory port shared by the pipeline memory stage and the display/LED scanner. The CPU has priority. The scanner gets free cycles, plus forced slots after a bounded starvation interval, during which the CPU is stalled for one cycle. The arbiter sits between the memory stage and `dmem`. It drives `dmem` address, write data and write enable, and returns read data to both requesters.

## Interface
- `STARVE_MAX`, 8: number of consecutive CPU-won cycles during a burst before a forced display slot. Legal range 1..255.
- `LEN_W`, 3: width of `disp_len`. A burst is `disp_len`+1 words, 1..2^LEN_W.

Ports:
- `clock` in 1: single system clock. All state changes on the rising edge.
- `aclr` in 1: reset, synchronous, active-high.
- `cpu_req` in 1: memory stage needs the port this cycle, for a load or a store.
- `cpu_we` in 1: memory-stage store enable.
- `cpu_addr` in 32: memory-stage address (ALU result).
- `cpu_wdata` in 32: memory-stage store data.
- `cpu_rdata` out 32: `mem_rdata` passthrough, combinational.
- `cpu_stall` out 1: the CPU access this cycle is not performed. The pipeline must hold all of its inputs.
- `disp_req` in 1: scanner burst request. Sampled only in IDLE.
- `disp_addr` in 32: burst base word address, latched on acceptance.
- `disp_len` in LEN_W: burst length minus one, latched on acceptance.
- `disp_ack` out 1: one-cycle pulse; the burst was accepted.
- `disp_valid` out 1: `disp_rdata` holds the next burst word.
- `disp_rdata` out 32: registered display read data.
- `disp_done` out 1: asserted together with the final `disp_valid`.
- `mem_addr` out 32: to `dmem` address.
- `mem_wdata` out 32: to `dmem` data. Equals `cpu_wdata` at all times.
- `mem_we` out 1: to `dmem` write enable.
- `mem_rdata` in 32: from `dmem`. `dmem` is clocked on the falling edge, so read data is valid before the next rising edge.

## Operation
- States:
  - IDLE: no burst active.
  - BURST: burst active; the CPU wins contention.
  - FORCE: forced display slot.
- Internal registers:
  - `base` (32 bits) and `last` (LEN_W bits), latched from `disp_addr` and `disp_len` on acceptance.
  - `idx` (LEN_W+1 bits): index of the next burst word.
  - `starve` (8 bits): consecutive CPU-won cycles.
- CPU slot: `mem_addr`=`cpu_addr`, `mem_we`=`cpu_req`&`cpu_we`, `cpu_stall`=0.
- Display slot:
  - `mem_addr` = `base` + `idx`, modulo 2^32.
  - `mem_we` = 0.
  - `mem_rdata` is registered into `disp_rdata` at the slot's closing edge.
  - `disp_valid` is high during the following cycle, and `idx` increments.
- IDLE:
  - Every cycle is a CPU slot.
  - If `disp_req`=1: latch `base` and `last`, clear `idx` and `starve`, and go to BURST. `disp_ack`=1 during the next cycle.
- BURST:
  - `cpu_req`=1: CPU slot.
    - `starve` increments.
    - If the incremented value equals `STARVE_MAX`, go to FORCE.
  - `cpu_req`=0: display slot.
    - `starve` clears.
    - If `idx`==`last`, go to IDLE.
- FORCE:
  - Display slot with `cpu_stall`=`cpu_req` and `mem_we`=0.
  - `starve` clears.
  - Go to IDLE if `idx`==`last`, otherwise to BURST.
- When the final word is issued, `disp_done` and `disp_valid` are both high the next cycle, which is the first IDLE cycle.
- `disp_req` outside IDLE is ignored. The scanner re-requests after `disp_done`.
- A request in the `disp_done` cycle is accepted.

## Timing
- Reset values:
  - State IDLE; `idx`, `starve`, `base`, `last` = 0.
  - `disp_ack`, `disp_valid`, `disp_done` = 0; `disp_rdata` = 0.
  - `cpu_stall` = 0.
  - `mem_addr`/`mem_we` follow the CPU-slot definition.
- `aclr` mid-burst:
  - The burst is abandoned and the next cycle is IDLE.
  - No `disp_valid` or `disp_done` for the remaining words.
  - A `disp_valid` pending from the slot before the reset edge is dropped.
- Latency:
  - Acceptance edge E; the first display slot is at the earliest the cycle after E, which is also the `disp_ack` cycle.
  - Data appears one cycle after its slot.
  - With the CPU idle, a burst of N words completes in N+1 cycles after E.
- Worst case under continuous `cpu_req`:
  - One display word per `STARVE_MAX`+1 cycles.
  - `cpu_stall` is high exactly 1 cycle in each such period.
- `cpu_stall` is combinational from state and `cpu_req`. It is never high in IDLE or BURST.
- A store is never lost: `mem_we` is forced 0 only while `cpu_stall`=1, and the pipeline re-presents the store the next cycle.

## Test plan
- Reset: hold `aclr` for 2 cycles with `disp_req`=1 -> no `disp_ack`; all outputs at their reset values; after release, `disp_ack` goes high one cycle after the first sampling edge.
- Idle-CPU burst: `disp_addr`=0x40, `disp_len`=3, `cpu_req`=0 -> `mem_addr` 0x40..0x43 on 4 consecutive cycles; `disp_valid` on the 4 following cycles with the preloaded data; `disp_done` with word 0x43; state IDLE.
- Starvation: `STARVE_MAX`=8, continuous `cpu_req` loads, `disp_len`=1 -> FORCE on the 9th and 18th burst cycles; `cpu_stall` high exactly those 2 cycles; both display words correct; `disp_done` after the second.
- CPU store priority: in BURST, `cpu_req`=`cpu_we`=1, `cpu_addr`=0x10, `cpu_wdata`=0xDEADBEEF -> written in that cycle; the display slot is deferred; a later burst read of 0x10 returns 0xDEADBEEF.
- Stall on store: a store arrives in a FORCE cycle -> `mem_we`=0, `cpu_stall`=1; the store is re-presented the next cycle and written; memory is unchanged during the FORCE cycle.
- Reset mid-burst and back-to-back:
  - Assert `aclr` after 2 of 4 words -> no further `disp_valid`/`disp_done`.
  - Separately, `disp_req` in the `disp_done` cycle -> `disp_ack` the next cycle; the new `base` is used.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the pipeline memory stage and the
// display scanner: the CPU wins contention, and the scanner gets idle cycles plus forced slots.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int STARVE_MAX = 8,
  parameter int LEN_W      = 3
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             disp_req,
  input  logic [31:0]      disp_addr,
  input  logic [LEN_W-1:0] disp_len,
  output logic             disp_ack,
  output logic             disp_valid,
  output logic [31:0]      disp_rdata,
  output logic             disp_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FORCE} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t           r_state;
  logic [31:0]      r_base;
  logic [LEN_W-1:0] r_last;
  logic [LEN_W:0]   r_idx;
  logic [7:0]       r_starve;
  logic             r_ack;
  logic             r_valid;
  logic             r_done;
  logic [31:0]      r_rdata;

  logic             w_disp_slot;
  logic             w_last_word;
  logic [7:0]       w_starve_inc;
  logic [31:0]      w_disp_addr;

  assign w_disp_slot  = (r_state == ST_FORCE) || ((r_state == ST_BURST) && !cpu_req);
  assign w_last_word  = (r_idx == {1'b0, r_last});
  assign w_starve_inc = r_starve + 8'd1;
  assign w_disp_addr  = r_base + 32'(r_idx);

  // A stalled CPU store is suppressed here and re-presented by the pipeline next cycle.
  assign mem_addr   = w_disp_slot ? w_disp_addr : cpu_addr;
  assign mem_we     = !w_disp_slot && cpu_req && cpu_we;
  assign mem_wdata  = cpu_wdata;
  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = (r_state == ST_FORCE) && cpu_req;

  assign disp_ack   = r_ack;
  assign disp_valid = r_valid;
  assign disp_done  = r_done;
  assign disp_rdata = r_rdata;

  always_ff @(posedge clock) begin
    if (aclr) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_last   <= '0;
      r_idx    <= '0;
      r_starve <= '0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (disp_req) begin
            r_base   <= disp_addr;
            r_last   <= disp_len;
            r_idx    <= '0;
            r_starve <= '0;
            r_ack    <= 1'b1;
            r_state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (cpu_req) begin
            r_starve <= w_starve_inc;
            if (w_starve_inc == STARVE_LIM) begin
              r_state <= ST_FORCE;
            end
          end else begin
            r_rdata  <= mem_rdata;
            r_valid  <= 1'b1;
            r_idx    <= r_idx + 1'b1;
            r_starve <= '0;
            if (w_last_word) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_FORCE: begin
          r_rdata  <= mem_rdata;
          r_valid  <= 1'b1;
          r_idx    <= r_idx + 1'b1;
          r_starve <= '0;
          if (w_last_word) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_BURST;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a falling-edge data memory model whose
// unwritten words read as 0xA0000000 + address.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        aclr;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        disp_req;
  logic [31:0] disp_addr;
  logic [2:0]  disp_len;
  logic        disp_ack, disp_valid, disp_done;
  logic [31:0] disp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0]  mem [0:255];
  logic [255:0] written = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.STARVE_MAX(8), .LEN_W(3)) dut (
    .clock(clock), .aclr(aclr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
    .disp_ack(disp_ack), .disp_valid(disp_valid), .disp_rdata(disp_rdata), .disp_done(disp_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always @(negedge clock) begin
    if (mem_we) begin
      mem[mem_addr[7:0]]     <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (32'hA000_0000 | {24'd0, mem_addr[7:0]});
  end

  // Step to 1ns after the next rising edge; inputs are driven there, outputs checked 2ns later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    aclr = 1'b1; disp_req = 1'b1; disp_addr = 32'h100; disp_len = 3'd2;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h55; cpu_wdata = 32'h0;
    next_cycle();
    next_cycle();
    #2;
    total++; if (disp_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", disp_ack); end
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", disp_valid); end
    total++; if (disp_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", disp_done); end
    total++; if (disp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", disp_rdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", cpu_stall); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 32'h55) begin bad++; $display("FAIL rst_addr got=%h want=00000055", mem_addr); end
    aclr = 1'b0;
    next_cycle();
    #2;
    total++; if (disp_ack !== 1'b1) begin bad++; $display("FAIL rst_first_ack got=%b want=1", disp_ack); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL rst_first_slot got=%h want=00000100", mem_addr); end
    aclr = 1'b1; disp_req = 1'b0;
    next_cycle();
    aclr = 1'b0;
    #2;
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL rst_drop_valid got=%b want=0", disp_valid); end
    total++; if (disp_ack !== 1'b0) begin bad++; $display("FAIL rst_drop_ack got=%b want=0", disp_ack); end
    total++; if (mem_addr !== 32'h55) begin bad++; $display("FAIL rst_idle_addr got=%h want=00000055", mem_addr); end
  endtask

  task automatic test_idle_burst();
    logic [31:0] exp_addr;
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h40; disp_len = 3'd3; cpu_req = 1'b0; cpu_addr = 32'h77;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      disp_req = 1'b0;
      #2;
      exp_addr = (k <= 4) ? 32'h40 + 32'(k - 1) : 32'h77;
      total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL idle_addr[%0d] got=%h want=%h", k, mem_addr, exp_addr); end
      total++; if (disp_ack !== (k == 1)) begin bad++; $display("FAIL idle_ack[%0d] got=%b", k, disp_ack); end
      total++; if (disp_valid !== (k >= 2)) begin bad++; $display("FAIL idle_valid[%0d] got=%b", k, disp_valid); end
      total++; if (disp_done !== (k == 5)) begin bad++; $display("FAIL idle_done[%0d] got=%b", k, disp_done); end
      if (k >= 2) begin
        total++;
        if (disp_rdata !== 32'hA000_0040 + 32'(k - 2)) begin
          bad++; $display("FAIL idle_data[%0d] got=%h want=%h", k, disp_rdata, 32'hA000_0040 + 32'(k - 2));
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    int stalls = 0;
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h20; disp_len = 3'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h08;
    for (int c = 1; c <= 19; c++) begin
      next_cycle();
      disp_req = 1'b0;
      if (c == 19) cpu_req = 1'b0;
      #2;
      if (cpu_stall === 1'b1) stalls++;
      exp_addr = (c == 9) ? 32'h20 : (c == 18) ? 32'h21 : 32'h08;
      total++; if (cpu_stall !== (c == 9 || c == 18)) begin bad++; $display("FAIL starve_stall[%0d] got=%b", c, cpu_stall); end
      total++; if (mem_addr !== exp_addr) begin bad++; $display("FAIL starve_addr[%0d] got=%h want=%h", c, mem_addr, exp_addr); end
      total++; if (disp_valid !== (c == 10 || c == 19)) begin bad++; $display("FAIL starve_valid[%0d] got=%b", c, disp_valid); end
      total++; if (disp_done !== (c == 19)) begin bad++; $display("FAIL starve_done[%0d] got=%b", c, disp_done); end
      if (c == 10) begin
        total++; if (disp_rdata !== 32'hA000_0020) begin bad++; $display("FAIL starve_w0 got=%h want=A0000020", disp_rdata); end
      end
      if (c == 19) begin
        total++; if (disp_rdata !== 32'hA000_0021) begin bad++; $display("FAIL starve_w1 got=%h want=A0000021", disp_rdata); end
      end
    end
    total++; if (stalls != 2) begin bad++; $display("FAIL starve_count got=%0d want=2", stalls); end
  endtask

  task automatic test_store_priority();
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h10; disp_len = 3'd0; cpu_req = 1'b0; cpu_we = 1'b0;
    next_cycle();
    disp_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    #2;
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL prio_we got=%b want=1", mem_we); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL prio_addr got=%h want=00000010", mem_addr); end
    total++; if (mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_wdata got=%h want=DEADBEEF", mem_wdata); end
    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b want=0", cpu_stall); end
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    total++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin bad++; $display("FAIL prio_slot got=%h/%b want=00000010/0", mem_addr, mem_we); end
    total++; if (disp_valid !== 1'b0) begin bad++; $display("FAIL prio_early_valid got=%b want=0", disp_valid); end
    next_cycle();
    #2;
    total++; if (disp_valid !== 1'b1 || disp_done !== 1'b1) begin bad++; $display("FAIL prio_done got=%b/%b want=1/1", disp_valid, disp_done); end
    total++; if (disp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_read got=%h want=DEADBEEF", disp_rdata); end
  endtask

  task automatic test_stall_on_store();
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h30; disp_len = 3'd1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      disp_req = 1'b0;
    end
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h1234_5678;
    #2;
    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL sst_stall got=%b want=1", cpu_stall); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL sst_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 32'h30) begin bad++; $display("FAIL sst_addr got=%h want=00000030", mem_addr); end
    #4;
    total++; if (written[8'h60] !== 1'b0) begin bad++; $display("FAIL sst_mem_untouched got=%b want=0", written[8'h60]); end
    next_cycle();
    #2;
    total++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("FAIL sst_retry got=%b/%b want=0/1", cpu_stall, mem_we); end
    total++; if (mem_addr !== 32'h60) begin bad++; $display("FAIL sst_retry_addr got=%h want=00000060", mem_addr); end
    total++; if (disp_valid !== 1'b1 || disp_rdata !== 32'hA000_0030) begin bad++; $display("FAIL sst_w0 got=%b/%h want=1/A0000030", disp_valid, disp_rdata); end
    #4;
    total++; if (mem[8'h60] !== 32'h1234_5678) begin bad++; $display("FAIL sst_mem_written got=%h want=12345678", mem[8'h60]); end
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    total++; if (mem_addr !== 32'h31) begin bad++; $display("FAIL sst_slot1 got=%h want=00000031", mem_addr); end
    next_cycle();
    #2;
    total++; if (disp_done !== 1'b1 || disp_rdata !== 32'hA000_0031) begin bad++; $display("FAIL sst_done got=%b/%h want=1/A0000031", disp_done, disp_rdata); end
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h40; disp_len = 3'd3; cpu_req = 1'b0; cpu_addr = 32'h99;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      disp_req = 1'b0;
      if (k == 4) aclr = 1'b0;
      #2;
      total++; if (disp_valid !== (k == 2 || k == 3)) begin bad++; $display("FAIL mid_valid[%0d] got=%b", k, disp_valid); end
      total++; if (disp_done !== 1'b0) begin bad++; $display("FAIL mid_done[%0d] got=%b want=0", k, disp_done); end
      if (k == 3) begin
        total++; if (disp_rdata !== 32'hA000_0041) begin bad++; $display("FAIL mid_w1 got=%h want=A0000041", disp_rdata); end
        aclr = 1'b1;
      end
      if (k >= 4) begin
        total++; if (mem_addr !== 32'h99) begin bad++; $display("FAIL mid_idle_addr[%0d] got=%h want=00000099", k, mem_addr); end
      end
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h40; disp_len = 3'd1; cpu_req = 1'b0;
    next_cycle();
    disp_req = 1'b0;
    next_cycle();
    next_cycle();
    disp_req = 1'b1; disp_addr = 32'h80; disp_len = 3'd0;
    #2;
    total++; if (disp_done !== 1'b1 || disp_rdata !== 32'hA000_0041) begin bad++; $display("FAIL b2b_done got=%b/%h want=1/A0000041", disp_done, disp_rdata); end
    next_cycle();
    disp_req = 1'b0;
    #2;
    total++; if (disp_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack got=%b want=1", disp_ack); end
    total++; if (mem_addr !== 32'h80) begin bad++; $display("FAIL b2b_base got=%h want=00000080", mem_addr); end
    next_cycle();
    #2;
    total++; if (disp_done !== 1'b1 || disp_rdata !== 32'hA000_0080) begin bad++; $display("FAIL b2b_word got=%b/%h want=1/A0000080", disp_done, disp_rdata); end
  endtask

  initial begin
    test_reset();
    test_idle_burst();
    test_starvation();
    test_store_priority();
    test_stall_on_store();
    test_reset_mid_burst();
    test_back_to_back();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
